mux_selftest: RTL
=================

# mux_selftest

On-board stimulus generator and checker for the lab's 3-bit-select logic mux. It sweeps every select code and switch combination into the mux under test and compares the mux output against a built-in golden model. It reports pass/fail, an error count and the first failing vector to LEDs or the seven-segment display. It sits between the board's start button (debounced upstream) and the mux's `sw0`/`sw1`/`select` inputs.

## Interface
- `SETTLE_CYCLES`, default 4: clocks to wait after applying a vector before sampling `mux_out_i`. Legal range 1..15.
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: synchronous one-cycle pulse that begins a sweep.
- `mux_out_i`, input, 1 bit: `out` of the mux under test.
- `sw0_o`, output, 1 bit: drives mux `sw0`.
- `sw1_o`, output, 1 bit: drives mux `sw1`.
- `select_o`, output, 3 bits: drives mux `select`.
- `busy`, output, 1 bit: high while a sweep is in progress.
- `done`, output, 1 bit: high once a sweep has completed; held until the next start or reset.
- `pass`, output, 1 bit: valid when `done`; 1 iff `err_count` == 0.
- `err_count`, output, 6 bits: number of mismatching vectors (0..32).
- `fail_valid`, output, 1 bit: high once a first mismatch has been captured.
- `fail_sel`, output, 3 bits: select code of the first mismatch.
- `fail_sw`, output, 2 bits: {sw1,sw0} of the first mismatch.

## Operation
- Golden function per select code, with a = sw0 and b = sw1:
  - 000: NOT a
  - 001: a (buffer)
  - 010: a XNOR b
  - 011: a XOR b
  - 100: a OR b
  - 101: a NOR b
  - 110: a AND b
  - 111: a NAND b
- Vector index `idx` is 5 bits, laid out as {select, sw1, sw0}. It runs 0..31 in ascending order.
- FSM states:
  - IDLE: outputs at reset values except `done`/`pass`/`err_count`/`fail_*`, which hold the previous results. `start` goes to APPLY; at the same time `idx`, `err_count` and `fail_*` clear, `done` clears, and `busy` sets.
  - APPLY: register `select_o`/`sw1_o`/`sw0_o` from `idx`; clear the settle counter; go to SETTLE.
  - SETTLE: count up to SETTLE_CYCLES, then go to CHECK.
  - CHECK: compare `mux_out_i` with the golden value. On mismatch, increment `err_count`. On the first mismatch only, load `fail_sel`/`fail_sw` and set `fail_valid`. If `idx` == 31, go to DONE; otherwise increment `idx` and go to APPLY.
  - DONE: set `done`, set `pass` = (`err_count` == 0), clear `busy`, return to IDLE.
- `start` while `busy` is ignored.
- `start` in IDLE after a completed sweep starts a fresh sweep and clears the previous results.
- `err_count` cannot overflow, since 32 ≤ 63. No saturation logic is required.
- `idx` increment never wraps past 31, because the exit is taken in CHECK.
- Reset (async, any state, including mid-sweep) forces IDLE and all outputs to 0. No partial results survive.

## Timing
- Reset values: `sw0_o`=0, `sw1_o`=0, `select_o`=000, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_sel`=000, `fail_sw`=00.
- `start` sampled high at edge N: `busy`=1 from N+1 (APPLY); vector 0 is on the outputs from N+2.
- Each vector takes SETTLE_CYCLES+2 clocks: 1 APPLY, SETTLE_CYCLES SETTLE, 1 CHECK.
- A full sweep takes 32·(SETTLE_CYCLES+2) clocks from the first APPLY; the default is 192.
- DONE takes one cycle. `done`/`pass` are high, and `busy` is low, from the edge after the last CHECK plus one.
- `mux_out_i` is sampled only in CHECK. It is a registered-path input with no synchronizer, because the mux shares `clk`.
- Mux outputs remain at vector 31 after the sweep until the next APPLY or reset.

## Structure
- Shared defines file `mux_defs` holds:
  - select encodings SEL_NOT..SEL_NAND (000..111);
  - FSM state encodings S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE;
  - NUM_VECTORS = 32.
- One sub-module, `mux_golden`: a purely combinational function of (select, sw0, sw1) that returns the expected output. It is reusable by the mux bench as its scoreboard.
- Top level contains the FSM, `idx`, settle counter and result registers. Target size is roughly 150–250 lines.

## Test plan
- **Correct mux model.** Pulse `start` with SETTLE_CYCLES=4. Required: `done`=1 exactly 193 clocks after the `start` edge, `pass`=1, `err_count`=0, `fail_valid`=0.
- **Mux with select 010 output inverted.** Required: `err_count`=4, `pass`=0, `fail_sel`=010, `fail_sw`=00.
- **Mux output stuck at 0.** Required: `err_count`=16, `fail_sel`=000, `fail_sw`=00.
- **`start` re-pulsed at cycle 60 of a sweep.** Required: ignored; `done` still at cycle 193; results identical to the single-start run.
- **`rst_n` low at cycle 50 mid-sweep.** Required: all outputs 0 immediately (asynchronous). A subsequent `start` runs a full 192-clock sweep from vector 0.
- **Back-to-back sweeps: stuck-at-0 mux, then correct mux.** Required: the second `start` clears `err_count`/`fail_valid`/`done`; the final `pass`=1.

Source files
------------

// File: rtl/mux_selftest_pkg.sv
// Shared definitions for the mux self-test block: select-code encodings of
// the mux under test, FSM state encoding and vector-sweep constants.
package mux_selftest_pkg;

  // Select codes of the mux under test and the function each one selects
  localparam logic [2:0] SEL_NOT  = 3'b000;
  localparam logic [2:0] SEL_BUF  = 3'b001;
  localparam logic [2:0] SEL_XNOR = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_OR   = 3'b100;
  localparam logic [2:0] SEL_NOR  = 3'b101;
  localparam logic [2:0] SEL_AND  = 3'b110;
  localparam logic [2:0] SEL_NAND = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Vector index is {select, sw1, sw0}
  localparam int NUM_VECTORS = 32;
  localparam int IDX_W       = 5;

endpackage

// File: rtl/mux_selftest_golden.sv
// Golden model of the lab mux: purely combinational expected output for a
// given select code and switch pair. Reusable as a scoreboard by mux benches.
//   i_sel  : select code
//   i_sw0  : switch a
//   i_sw1  : switch b
//   o_exp  : expected mux output
module mux_golden
  import mux_selftest_pkg::*;
(
  input  logic [2:0] i_sel,
  input  logic       i_sw0,
  input  logic       i_sw1,
  output logic       o_exp
);

  always_comb begin
    o_exp = 1'b0;
    case (i_sel)
      SEL_NOT:  o_exp = ~i_sw0;
      SEL_BUF:  o_exp =  i_sw0;
      SEL_XNOR: o_exp = ~(i_sw0 ^ i_sw1);
      SEL_XOR:  o_exp =  i_sw0 ^ i_sw1;
      SEL_OR:   o_exp =  i_sw0 | i_sw1;
      SEL_NOR:  o_exp = ~(i_sw0 | i_sw1);
      SEL_AND:  o_exp =  i_sw0 & i_sw1;
      SEL_NAND: o_exp = ~(i_sw0 & i_sw1);
      default:  o_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_selftest.sv
// On-board stimulus generator/checker for the 3-bit-select lab mux. A start
// pulse sweeps all 32 {select, sw1, sw0} vectors, waits SETTLE_CYCLES after
// each, samples the mux output and compares it with the golden model.
//   clk, rst_n            : clock, async active-low reset
//   start                 : one-cycle pulse, begins a sweep (ignored if busy)
//   mux_out_i             : output of the mux under test (same clock domain)
//   sw0_o, sw1_o, select_o: stimulus to the mux under test
//   busy, done, pass      : sweep status; pass valid while done
//   err_count             : number of mismatching vectors
//   fail_valid/sel/sw     : first mismatching vector
module mux_selftest
  import mux_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out_i,
  output logic       sw0_o,
  output logic       sw1_o,
  output logic [2:0] select_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_sel,
  output logic [1:0] fail_sw
);

  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_cnt;
  logic             w_exp;

  // Expected value is taken from the registered stimulus, i.e. exactly what
  // the mux is seeing during CHECK.
  mux_golden u_golden (
    .i_sel (select_o),
    .i_sw0 (sw0_o),
    .i_sw1 (sw1_o),
    .o_exp (w_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_APPLY;
      S_APPLY:  w_next = S_SETTLE;
      S_SETTLE: if (r_cnt == CNT_LAST) w_next = S_CHECK;
      S_CHECK:  w_next = (r_idx == IDX_LAST) ? S_DONE : S_APPLY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      sw0_o      <= 1'b0;
      sw1_o      <= 1'b0;
      select_o   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_sel   <= '0;
      fail_sw    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Previous results and stimulus hold until a new sweep starts
          if (start) begin
            r_idx      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_sel   <= '0;
            fail_sw    <= '0;
          end
        end
        S_APPLY: begin
          {select_o, sw1_o, sw0_o} <= r_idx;
          r_cnt                    <= '0;
        end
        S_SETTLE: r_cnt <= r_cnt + 4'd1;
        S_CHECK: begin
          if (mux_out_i != w_exp) begin
            err_count <= err_count + 6'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_sel   <= select_o;
              fail_sw    <= {sw1_o, sw0_o};
            end
          end
          if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          done <= 1'b1;
          pass <= (err_count == '0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
